// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble controller for the 5-stage pipeline: load-use, multicycle
// execute and redirect hazards, data-memory handshake with timeout, perf counters.
`ifndef LOAD_WIDTH
`define LOAD_WIDTH 3
`endif
`ifndef STORE_WIDTH
`define STORE_WIDTH 2
`endif

module pipe_hazard_ctrl #(
  parameter int LOAD_WIDTH  = `LOAD_WIDTH,
  parameter int STORE_WIDTH = `STORE_WIDTH,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [4:0]             D_rs1_i,
  input  logic [4:0]             D_rs2_i,
  input  logic                   D_use_rs1_i,
  input  logic                   D_use_rs2_i,
  input  logic [LOAD_WIDTH-1:0]  DD_load_op_i,
  input  logic                   DD_need_dstE_i,
  input  logic [4:0]             DD_dstE_i,
  input  logic                   ex_busy_i,
  input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
  input  logic [STORE_WIDTH-1:0] ED_store_op_i,
  input  logic                   ED_jmp_sel_i,
  input  logic                   dmem_ack_i,
  output logic                   dmem_req_o,
  output logic                   F_stall_o,
  output logic                   F_bubble_o,
  output logic                   D_stall_o,
  output logic                   D_bubble_o,
  output logic                   E_stall_o,
  output logic                   E_bubble_o,
  output logic                   M_bubble_o,
  output logic                   bus_err_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} mem_state_e;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  mem_state_e      state_q;
  logic [TO_W-1:0] wait_cnt_q;
  logic            mem_op;
  logic            mem_req;
  logic            mem_stall;
  logic            load_use;
  logic            redirect;

  // Memory handshake decode; ERR drops the request so the held access retires.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mem_op    = (|ED_load_op_i) | (|ED_store_op_i);
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        mem_req   = mem_op;
        mem_stall = mem_op & ~dmem_ack_i;
      end
      S_WAIT: begin
        mem_req   = 1'b1;
        mem_stall = ~dmem_ack_i;
      end
      default: ;
    endcase
  end

  assign load_use = (|DD_load_op_i) & DD_need_dstE_i & (DD_dstE_i != 5'd0) &
                    ((D_use_rs1_i & (D_rs1_i == DD_dstE_i)) |
                     (D_use_rs2_i & (D_rs2_i == DD_dstE_i)));

  assign redirect = ~mem_stall & ED_jmp_sel_i;

  // Strobes in strict priority; reset forces every register to flush.
  always_comb begin
    dmem_req_o = 1'b0;
    F_stall_o  = 1'b0;
    F_bubble_o = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    if (!rst_n_i) begin
      F_bubble_o = 1'b1;
      D_bubble_o = 1'b1;
      E_bubble_o = 1'b1;
      M_bubble_o = 1'b1;
    end else begin
      dmem_req_o = mem_req;
      if (mem_stall) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
      end else if (ED_jmp_sel_i) begin
        F_bubble_o = 1'b1;
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
      end else if (ex_busy_i) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
      end else if (load_use) begin
        F_stall_o  = 1'b1;
        D_bubble_o = 1'b1;
      end
    end
  end

  // Memory FSM, sticky bus error and performance counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      bus_err_o   <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      unique case (state_q)
        S_IDLE: begin
          if (mem_op && !dmem_ack_i) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= TO_W'(1);
          end
        end
        S_WAIT: begin
          if (dmem_ack_i) begin
            state_q <= S_IDLE;
          end else if (wait_cnt_q < TIMEOUT_C) begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end else begin
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          bus_err_o <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (F_stall_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect)  flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int LW   = 3;
  localparam int SW   = 2;
  localparam int TOUT = 4;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1, rs2, dst;
  logic          use1, use2, need_dst, busy, jmp, ack;
  logic [LW-1:0] dd_ld, ed_ld;
  logic [SW-1:0] ed_st;
  logic          req, fs, fb, ds, db, es, eb, mb, bus_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles already spent stalling on the current access,
  // whether this cycle is the abandon cycle, and the expected registered outputs.
  int            waited;
  bit            err_cyc;
  bit            bus_err_m;
  logic [CW-1:0] stall_m, flush_m;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LOAD_WIDTH(LW), .STORE_WIDTH(SW), .TIMEOUT(TOUT), .TO_W(8), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .D_rs1_i(rs1), .D_rs2_i(rs2), .D_use_rs1_i(use1), .D_use_rs2_i(use2),
    .DD_load_op_i(dd_ld), .DD_need_dstE_i(need_dst), .DD_dstE_i(dst),
    .ex_busy_i(busy), .ED_load_op_i(ed_ld), .ED_store_op_i(ed_st),
    .ED_jmp_sel_i(jmp), .dmem_ack_i(ack), .dmem_req_o(req),
    .F_stall_o(fs), .F_bubble_o(fb), .D_stall_o(ds), .D_bubble_o(db),
    .E_stall_o(es), .E_bubble_o(eb), .M_bubble_o(mb), .bus_err_o(bus_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] observed();
    return {req, fs, fb, ds, db, es, eb, mb};
  endfunction

  // {req, F_stall, F_bubble, D_stall, D_bubble, E_stall, E_bubble, M_bubble}
  function automatic logic [7:0] model_strobes(input bit m_req, input bit m_stall);
    bit lu;
    lu = (dd_ld != 0) && need_dst && (dst != 0) &&
         ((use1 && rs1 == dst) || (use2 && rs2 == dst));
    if (m_stall)   return {m_req, 7'b1010101};
    else if (jmp)  return {m_req, 7'b0101010};
    else if (busy) return {m_req, 7'b1010010};
    else if (lu)   return {m_req, 7'b1001000};
    else           return {m_req, 7'b0000000};
  endfunction

  task automatic model_reset();
    waited    = 0;
    err_cyc   = 0;
    bus_err_m = 0;
    stall_m   = '0;
    flush_m   = '0;
  endtask

  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; dst = '0; use1 = 0; use2 = 0; need_dst = 0;
    busy = 0; jmp = 0; ack = 0; dd_ld = '0; ed_ld = '0; ed_st = '0;
  endtask

  task automatic set_load_use(input logic [4:0] d);
    dd_ld = LW'(1); need_dst = 1; dst = d; rs1 = 5'd5; use1 = 1;
  endtask

  // Called at a falling edge with inputs already driven; checks, then steps one clock.
  task automatic cycle(input string tag);
    logic [7:0] e;
    bit mem_op, m_req, m_stall;
    #1;
    mem_op  = (ed_ld != 0) || (ed_st != 0);
    m_req   = err_cyc ? 1'b0 : ((waited > 0) || mem_op);
    m_stall = m_req && !ack;
    e = model_strobes(m_req, m_stall);
    check({tag, "/strobes"}, 64'(observed()), 64'(e));
    check({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
    check({tag, "/flush_cnt"}, 64'(flush_cnt), 64'(flush_m));
    check({tag, "/bus_err"}, 64'(bus_err), 64'(bus_err_m));
    @(posedge clk);
    if (err_cyc) begin
      err_cyc   = 0;
      bus_err_m = 1;
    end else if (m_stall) begin
      waited++;
      if (waited > TOUT) begin
        err_cyc = 1;
        waited  = 0;
      end
    end else begin
      waited = 0;
    end
    if (e[6]) stall_m++;
    if (!m_stall && jmp) flush_m++;
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    #1;
    check({tag, "/strobes"}, 64'(observed()), 64'(8'b0010_1011));
    check({tag, "/stall_cnt"}, 64'(stall_cnt), 64'd0);
    check({tag, "/flush_cnt"}, 64'(flush_cnt), 64'd0);
    check({tag, "/bus_err"}, 64'(bus_err), 64'd0);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    reset_check("por");
    rst_n = 1'b1;
    cycle("idle");

    // Load-use costs one stall cycle; destination x0 never stalls.
    set_load_use(5'd5);
    cycle("load_use");
    clear_inputs();
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    set_load_use(5'd0);
    rs1 = 5'd0;
    cycle("lu_x0");
    clear_inputs();

    // Redirect beats load-use.
    set_load_use(5'd5);
    jmp = 1;
    cycle("jmp_lu");
    clear_inputs();
    check("jmp_flush_cnt", 64'(flush_cnt), 64'd1);

    // Load with ack in the fourth cycle.
    ed_ld = LW'(2);
    for (int i = 0; i < 3; i++) cycle("mem_wait");
    ack = 1;
    cycle("mem_ack");
    clear_inputs();
    check("mem_stall_cnt", 64'(stall_cnt), 64'd4);

    // Immediate ack: no stall.
    ed_ld = LW'(1);
    ack = 1;
    cycle("mem_ack0");
    clear_inputs();
    cycle("idle2");

    // Store never acknowledged: five stall cycles, then the abandon cycle.
    ed_st = SW'(1);
    for (int i = 0; i < 6; i++) cycle("timeout");
    clear_inputs();
    for (int i = 0; i < 3; i++) cycle("post_err");
    check("err_sticky", 64'(bus_err), 64'd1);
    check("to_stall_cnt", 64'(stall_cnt), 64'd9);

    // Memory stall dominates execute-busy and load-use; then busy alone.
    ed_ld = LW'(3);
    busy = 1;
    set_load_use(5'd5);
    cycle("prio_mem");
    ack = 1;
    cycle("prio_ack");
    clear_inputs();
    busy = 1;
    cycle("prio_busy");
    clear_inputs();

    // Random traffic with small register ranges so hazards collide often.
    for (int n = 0; n < 1500; n++) begin
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      dst      = 5'($urandom_range(0, 3));
      use1     = 1'($urandom_range(0, 1));
      use2     = 1'($urandom_range(0, 1));
      need_dst = ($urandom_range(0, 3) != 0);
      dd_ld    = ($urandom_range(0, 2) == 0) ? LW'($urandom_range(1, 7)) : '0;
      busy     = ($urandom_range(0, 4) == 0);
      jmp      = ($urandom_range(0, 6) == 0);
      ed_ld    = ($urandom_range(0, 4) == 0) ? LW'($urandom_range(1, 7)) : '0;
      ed_st    = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(1, 3)) : '0;
      ack      = ($urandom_range(0, 4) < 2);
      cycle("rand");
    end
    clear_inputs();
    for (int i = 0; i < 8; i++) cycle("drain");

    // Reset in WAIT with wait count 3: access abandoned, nothing flagged.
    ed_ld = LW'(1);
    for (int i = 0; i < 3; i++) cycle("pre_rst");
    rst_n = 1'b0;
    reset_check("rst_wait");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_check("rst_hold");
    rst_n = 1'b1;
    clear_inputs();
    cycle("rst_release");
    cycle("rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
